fakeram_512x64_bist: RTL and testbench
======================================

FAKERAM_512X64_BIST -- requirements
Module: fakeram_512x64_bist

Interface
REQ-001 SHALL have parameter BITS, default 64, meaning RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning RAM address width (depth 2^ADDR_WIDTH = 512).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse launching a test.
REQ-006 SHALL have port pattern_i  input  BITS  background pattern P, sampled on accepted start.
REQ-007 SHALL have ports busy_o, done_o, pass_o  output  1 each  test running; test complete (sticky); complete with zero errors.
REQ-008 SHALL have port fail_addr_o  output  ADDR_WIDTH  address of first miscompare.
REQ-009 SHALL have port err_count_o  output  16  miscompare count, saturating at 16'hFFFF.
REQ-010 SHALL have RAM-side ports ce_o, we_o (1), addr_o (ADDR_WIDTH), wd_o, wmsk_o (BITS) output, rd_i (BITS) input, wired to fakeram_512x64 cei, wei, addri, wdi, wmski, rd_out.

Function
REQ-011 SHALL run a march sequence in states IDLE, W0, R0W1, R1, DRAIN, DONE.
REQ-012 SHALL accept start_i only in IDLE or DONE; it SHALL be ignored while busy_o=1.
REQ-013 On accepted start SHALL latch P, clear done_o/pass_o/err_count_o/fail_addr_o, enter W0 with addr=0.
REQ-014 W0: one write per cycle, ascending 0..511, wd_o=P; after addr 511 -> R0W1, addr=0.
REQ-015 R0W1: per address two cycles, ascending: read cycle (ce=1, we=0), then write cycle (ce=1, we=1, wd_o=~P); after write of 511 -> R1, addr=511.
REQ-016 R1: one read per cycle, descending 511..0; after read of addr 0 -> DRAIN.
REQ-017 RAM read latency is 1 cycle: data for a read issued in cycle N SHALL be compared against rd_i in cycle N+1, using a registered expected value and address.
REQ-018 Expected data SHALL be P for R0W1 reads and ~P for R1 reads.
REQ-019 DRAIN SHALL last one cycle (final compare only, ce_o=0), then -> DONE.
REQ-020 Total run SHALL be 2049 cycles from the start-accept edge to done_o=1 (512+1024+512+1).
REQ-021 wmsk_o SHALL be all-ones whenever we_o=1; ce_o=0 and we_o=0 in IDLE, DRAIN, DONE.
REQ-022 On miscompare SHALL increment err_count_o (saturating) and, if first error of run, capture fail_addr_o.
REQ-023 pass_o SHALL equal done_o AND err_count_o==0; busy_o=1 exactly in W0, R0W1, R1, DRAIN.
REQ-024 A start in DONE SHALL restart identically to a start in IDLE.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, addr=0, ce_o=we_o=0, done_o=pass_o=0, err_count_o=0, fail_addr_o=0, wd_o=0, compare pipeline invalid.
REQ-026 Reset mid-run SHALL abort without any further RAM write; RAM contents are then undefined.
REQ-027 After rst_n deasserts, the block SHALL wait in IDLE for start_i.

Structure
REQ-028 State enumeration and the constants 16-bit error width and saturation value SHALL live in a shared package fakeram_bist_pkg.
REQ-029 A sub-module fakeram_bist_cmp (registered expected/address/valid, compare, saturating counter, first-fail capture) SHALL be instantiated once.
REQ-030 The RAM SHALL NOT be instantiated inside this block; the bench connects fakeram_512x64.

Verification
REQ-031 Reset, start with P=64'hA5A5_A5A5_A5A5_A5A5 on good RAM -> done_o after 2049 cycles, pass_o=1, err_count_o=0.
REQ-032 RAM model with bit 3 stuck-at-0 at addr 9'h07F, P=64'hFFFF_FFFF_FFFF_FFFF -> err_count_o=1 (R0W1 read), fail_addr_o=9'h07F, pass_o=0.
REQ-033 Stuck bit at addr 9'h000 and 9'h1FF, P=0 -> err_count_o=2, fail_addr_o=9'h1FF (descending R1 hits 511 first), checks DRAIN compare of addr 0.
REQ-034 start_i pulsed at cycle 100 of a run -> ignored, total still 2049 cycles, results unchanged.
REQ-035 rst_n low at cycle 700 (in R0W1) -> same cycle ce_o=we_o=0, busy_o=0; new start then yields pass_o=1.
REQ-036 All-bits-faulty model (rd_i=~expected always) -> err_count_o=1024, fail_addr_o=0; forced 70000 errors -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/fakeram_bist_pkg.sv
// Shared definitions for the fakeram_512x64 march BIST.
//   bist_state_e : march sequencer states
//   ERR_W        : width of the miscompare counter
//   ERR_SAT      : value at which the miscompare counter holds
package fakeram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_W0    = 3'd1,
        ST_R0W1  = 3'd2,
        ST_R1    = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } bist_state_e;

    localparam int              ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/fakeram_bist_cmp.sv
// Read-data checker for the march BIST.
// A read issued in one cycle is checked against the RAM output in the next
// cycle, using an expected value and address registered at issue time.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_clr         : clears counter, first-fail address and pending compare
//   i_issue       : a RAM read is being issued this cycle
//   i_exp, i_addr : expected data and address of that read
//   i_rd          : RAM read data (valid the cycle after issue)
//   o_err_count   : saturating miscompare count
//   o_fail_addr   : address of the first miscompare since the last clear
module fakeram_bist_cmp
    import fakeram_bist_pkg::*;
#(
    parameter int BITS       = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_issue,
    input  logic [BITS-1:0]       i_exp,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BITS-1:0]       i_rd,
    output logic [ERR_W-1:0]      o_err_count,
    output logic [ADDR_WIDTH-1:0] o_fail_addr
);

    logic                  r_vld_p1;
    logic [BITS-1:0]       r_exp_p1;
    logic [ADDR_WIDTH-1:0] r_addr_p1;
    logic [ERR_W-1:0]      r_err;
    logic [ADDR_WIDTH-1:0] r_fail;
    logic                  w_miss;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_SAT) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    // Stage p1: the RAM output now belongs to the read registered last cycle.
    assign w_miss = r_vld_p1 && (i_rd != r_exp_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_exp_p1  <= '0;
            r_addr_p1 <= '0;
            r_err     <= '0;
            r_fail    <= '0;
        end else if (i_clr) begin
            r_vld_p1 <= 1'b0;
            r_err    <= '0;
            r_fail   <= '0;
        end else begin
            r_vld_p1 <= i_issue;
            if (i_issue) begin
                r_exp_p1  <= i_exp;
                r_addr_p1 <= i_addr;
            end
            if (w_miss) begin
                r_err <= sat_inc(r_err);
                // The counter never wraps back to zero, so zero means "no error yet".
                if (r_err == '0) begin
                    r_fail <= r_addr_p1;
                end
            end
        end
    end

    assign o_err_count = r_err;
    assign o_fail_addr = r_fail;

endmodule

// File: rtl/fakeram_512x64_bist.sv
// March BIST controller for a fakeram_512x64 macro (RAM lives outside).
// Sequence: W0 (write P ascending), R0W1 (read P / write ~P ascending),
// R1 (read ~P descending), DRAIN (last compare), DONE (results held).
//   clk, rst_n           : clock, asynchronous active-low reset
//   start_i, pattern_i   : start pulse and background pattern P
//   busy_o, done_o       : test running; test complete (held until restart)
//   pass_o               : complete with zero miscompares
//   fail_addr_o          : first failing address
//   err_count_o          : saturating miscompare count
//   ce_o, we_o, addr_o,
//   wd_o, wmsk_o, rd_i   : RAM port (cei, wei, addri, wdi, wmski, rd_out)
module fakeram_512x64_bist
    import fakeram_bist_pkg::*;
#(
    parameter int BITS       = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BITS-1:0]       pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [ERR_W-1:0]      err_count_o,
    output logic                  ce_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [BITS-1:0]       wd_o,
    output logic [BITS-1:0]       wmsk_o,
    input  logic [BITS-1:0]       rd_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    bist_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_phase;   // R0W1: 0 = read cycle, 1 = write cycle
    logic [BITS-1:0]       r_pat;

    bist_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_phase_nxt;
    logic                  w_start_acc;
    logic                  w_issue;
    logic [BITS-1:0]       w_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wr_phase <= 1'b0;
            r_pat      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_wr_phase <= w_phase_nxt;
            if (w_start_acc) begin
                r_pat <= pattern_i;
            end
        end
    end

    // RAM controls are decoded from the current state, so an asynchronous
    // reset drops ce/we in the same cycle and no further write can occur.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_wr_phase;
        w_start_acc = 1'b0;
        w_exp       = '0;
        ce_o        = 1'b0;
        we_o        = 1'b0;
        wd_o        = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_W0;
                    w_addr_nxt  = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            ST_W0: begin
                ce_o = 1'b1;
                we_o = 1'b1;
                wd_o = r_pat;
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = ST_R0W1;
                    w_addr_nxt  = '0;
                    w_phase_nxt = 1'b0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_ONE;
                end
            end
            ST_R0W1: begin
                ce_o = 1'b1;
                if (!r_wr_phase) begin
                    w_exp       = r_pat;
                    w_phase_nxt = 1'b1;
                end else begin
                    we_o        = 1'b1;
                    wd_o        = ~r_pat;
                    w_phase_nxt = 1'b0;
                    if (r_addr == ADDR_MAX) begin
                        w_state_nxt = ST_R1;
                        w_addr_nxt  = ADDR_MAX;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_ONE;
                    end
                end
            end
            ST_R1: begin
                ce_o  = 1'b1;
                w_exp = ~r_pat;
                if (r_addr == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_addr_nxt = r_addr - ADDR_ONE;
                end
            end
            // Only the compare of the final R1 read happens here.
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        wmsk_o = we_o ? '1 : '0;
    end

    assign w_issue = ce_o & ~we_o;
    assign addr_o  = r_addr;
    assign busy_o  = (r_state == ST_W0) || (r_state == ST_R0W1) ||
                     (r_state == ST_R1) || (r_state == ST_DRAIN);
    assign done_o  = (r_state == ST_DONE);
    assign pass_o  = done_o && (err_count_o == '0);

    fakeram_bist_cmp #(
        .BITS       (BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_start_acc),
        .i_issue     (w_issue),
        .i_exp       (w_exp),
        .i_addr      (r_addr),
        .i_rd        (rd_i),
        .o_err_count (err_count_o),
        .o_fail_addr (fail_addr_o)
    );

endmodule

// File: tb/tb_fakeram_512x64_bist.sv
// Bench for fakeram_512x64_bist: a fault-injectable RAM model stands in for
// fakeram_512x64; each completed run is checked by a monitor against a
// scoreboard entry produced by a march-algorithm reference model.
module tb_fakeram_512x64_bist;

    localparam int BITS       = 64;
    localparam int AW         = 9;
    localparam int DEPTH      = 512;
    localparam int RUN_CYCLES = 2049;

    typedef struct {
        int          done_at;
        logic [15:0] err;
        logic [8:0]  fail;
        logic        pass;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [BITS-1:0] pattern_i = '0;
    logic            busy_o, done_o, pass_o;
    logic [AW-1:0]   fail_addr_o;
    logic [15:0]     err_count_o;
    logic            ce_o, we_o;
    logic [AW-1:0]   addr_o;
    logic [BITS-1:0] wd_o, wmsk_o;
    logic [BITS-1:0] rd_i = '0;

    // standalone checker instance used to reach the counter's saturation point
    logic            sat_rst_n = 1'b0;
    logic            sat_clr = 1'b0;
    logic            sat_issue = 1'b0;
    logic [BITS-1:0] sat_exp = '0;
    logic [AW-1:0]   sat_addr = '0;
    logic [BITS-1:0] sat_rd = '1;
    logic [15:0]     sat_err;
    logic [AW-1:0]   sat_fail;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [BITS-1:0] mem [DEPTH];
    logic [BITS-1:0] s0  [DEPTH];
    logic [BITS-1:0] s1  [DEPTH];
    bit              inv = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fakeram_512x64_bist #(.BITS(BITS), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .pattern_i   (pattern_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_addr_o (fail_addr_o),
        .err_count_o (err_count_o),
        .ce_o        (ce_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wd_o        (wd_o),
        .wmsk_o      (wmsk_o),
        .rd_i        (rd_i)
    );

    fakeram_bist_cmp #(.BITS(BITS), .ADDR_WIDTH(AW)) u_sat (
        .clk         (clk),
        .rst_n       (sat_rst_n),
        .i_clr       (sat_clr),
        .i_issue     (sat_issue),
        .i_exp       (sat_exp),
        .i_addr      (sat_addr),
        .i_rd        (sat_rd),
        .o_err_count (sat_err),
        .o_fail_addr (sat_fail)
    );

    // Read path of a RAM with per-address stuck-at-0/1 cells and optional inversion.
    function automatic logic [BITS-1:0] faulty(input int a, input logic [BITS-1:0] v);
        return ((v & ~s0[a]) | s1[a]) ^ {BITS{inv}};
    endfunction

    always @(posedge clk) begin
        if (ce_o) begin
            if (we_o) mem[addr_o] <= (wd_o & wmsk_o) | (mem[addr_o] & ~wmsk_o);
            else      rd_i <= faulty(int'(addr_o), mem[addr_o]);
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s0[a] = '0;
            s1[a] = '0;
        end
        inv = 1'b0;
    endtask

    // March C- style reference: write P everywhere, ascending read P / write ~P,
    // descending read ~P; count mismatches and remember the first failing address.
    function automatic exp_t model(input logic [BITS-1:0] p);
        exp_t            e;
        logic [BITS-1:0] m [DEPTH];
        int              errs = 0;
        int              first = -1;
        for (int a = 0; a < DEPTH; a++) m[a] = p;
        for (int a = 0; a < DEPTH; a++) begin
            if (faulty(a, m[a]) !== p) begin
                if (first < 0) first = a;
                errs++;
            end
            m[a] = ~p;
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            if (faulty(a, m[a]) !== ~p) begin
                if (first < 0) first = a;
                errs++;
            end
        end
        e.done_at = 0;
        e.err     = (errs > 65535) ? 16'hFFFF : 16'(errs);
        e.fail    = (first < 0) ? 9'd0 : 9'(first);
        e.pass    = (errs == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic launch(input logic [BITS-1:0] p, input bit expect_done);
        exp_t e;
        @(negedge clk);
        start_i   = 1'b1;
        pattern_i = p;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        pattern_i = {$urandom, $urandom};
        chk("busy_after_start", busy_o, 1);
        chk("done_cleared", done_o, 0);
        chk("err_cleared", err_count_o, 0);
        chk("first_ce_we", {ce_o, we_o}, 2'b11);
        chk("first_wdata", wd_o, p);
        chk("first_addr", addr_o, 0);
        if (expect_done) begin
            e = model(p);
            e.done_at = cyc + RUN_CYCLES;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_o !== 1'b1 && n < RUN_CYCLES + 50) begin
            @(negedge clk);
            n++;
        end
        if (done_o !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: done_o=%b after %0d cycles, required 1", done_o, n);
        end
        @(negedge clk);
    endtask

    // Monitor: every rising done_o is matched against the oldest scoreboard entry.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_o === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: done_o=1 at cycle %0d, no run expected", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_at);
                    chk("err_count", err_count_o, e.err);
                    chk("fail_addr", fail_addr_o, e.fail);
                    chk("pass", pass_o, e.pass);
                    chk("busy_at_done", busy_o, 0);
                end
            end
            prev = (done_o === 1'b1);
        end
    end

    task automatic main_seq();
        int a;
        int b;
        // good RAM
        launch(64'hA5A5_A5A5_A5A5_A5A5, 1);
        wait_done();
        // bit 3 stuck-at-0 at 0x07F, all-ones background
        clear_faults();
        s0[9'h07F] = 64'h8;
        launch(64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_done();
        // stuck-at-0 at both ends, zero background: only R1 and DRAIN compares see it
        clear_faults();
        s0[9'h000] = 64'h20;
        s0[9'h1FF] = 64'h20;
        launch(64'h0, 1);
        wait_done();
        // stray start during a run must be ignored
        clear_faults();
        launch(64'hA5A5_A5A5_A5A5_A5A5, 1);
        repeat (100) @(negedge clk);
        start_i   = 1'b1;
        pattern_i = {$urandom, $urandom};
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_after_ignored_start", busy_o, 1);
        wait_done();
        // reset in the middle of R0W1
        launch({$urandom, $urandom}, 0);
        repeat (700) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ce", ce_o, 0);
        chk("abort_we", we_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_wd", wd_o, 0);
        chk("abort_err", err_count_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", busy_o, 0);
        chk("idle_after_reset_done", done_o, 0);
        launch({$urandom, $urandom}, 1);
        wait_done();
        // every read returns the complement of the stored word
        clear_faults();
        inv = 1'b1;
        launch({$urandom, $urandom}, 1);
        wait_done();
        // random single stuck-at faults with random backgrounds
        for (int k = 0; k < 3; k++) begin
            clear_faults();
            a = $urandom_range(0, DEPTH - 1);
            b = $urandom_range(0, BITS - 1);
            if ($urandom_range(0, 1) == 1) s1[a][b] = 1'b1;
            else                           s0[a][b] = 1'b1;
            launch({$urandom, $urandom}, 1);
            wait_done();
        end
    endtask

    task automatic sat_seq();
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            sat_issue = 1'b1;
            sat_addr  = (i == 0) ? 9'h0AB : 9'($urandom);
            @(negedge clk);
        end
        sat_issue = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_err_count", sat_err, 16'hFFFF);
        chk("sat_fail_addr", sat_fail, 9'h0AB);
    endtask

    initial begin
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_pass", pass_o, 0);
        chk("reset_err", err_count_o, 0);
        chk("reset_fail_addr", fail_addr_o, 0);
        chk("reset_ce_we", {ce_o, we_o}, 2'b00);
        chk("reset_wd", wd_o, 0);
        rst_n     = 1'b1;
        sat_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_waits", busy_o, 0);
        fork
            main_seq();
            sat_seq();
        join
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
